// File: rtl/sobel_frame_ctrl.sv
// Sobel frame sequencer: streams one frame from input memory into the
// RGB FIFO and drains the Sobel FIFO into output memory, with a watchdog.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH    = 720,
  parameter int IMG_HEIGHT   = 540,
  parameter int RGB_DWIDTH   = 24,
  parameter int SOBEL_DWIDTH = 8,
  parameter int ADDR_WIDTH   = 20,
  parameter int TIMEOUT      = 8192
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             frame_count,
  output logic                    in_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   in_mem_addr,
  input  logic [RGB_DWIDTH-1:0]   in_mem_rdata,
  output logic                    fifo_rgb_wr_en,
  output logic [RGB_DWIDTH-1:0]   fifo_rgb_din,
  input  logic                    fifo_rgb_full,
  output logic                    fifo_sobel_rd_en,
  input  logic [SOBEL_DWIDTH-1:0] fifo_sobel_dout,
  input  logic                    fifo_sobel_empty,
  output logic                    out_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   out_mem_addr,
  output logic [SOBEL_DWIDTH-1:0] out_mem_wdata
);

  localparam int N   = IMG_WIDTH * IMG_HEIGHT;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_WIDTH:0]   C_N   = (ADDR_WIDTH+1)'(N);
  localparam logic [ADDR_WIDTH:0]   C_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [WDW-1:0]        W_ONE = WDW'(1);
  localparam logic [WDW-1:0]        W_LIM = WDW'(TIMEOUT - 1);

  logic [1:0]              r_state;
  logic [ADDR_WIDTH:0]     r_rd_left;
  logic [ADDR_WIDTH:0]     r_wr_left;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [WDW-1:0]          r_wd;
  logic                    r_pend;
  logic                    r_skid_v;
  logic [RGB_DWIDTH-1:0]   r_skid;
  logic                    r_out_wr_en;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic [SOBEL_DWIDTH-1:0] r_out_wdata;
  logic [15:0]             r_frame_count;

  logic w_run;
  logic w_go;
  logic w_rd_issue;
  logic w_sob_rd;
  logic w_last;
  logic w_wd_fire;

  assign w_run      = (r_state == S_RUN);
  assign w_go       = (r_state == S_IDLE) && start;
  assign w_rd_issue = w_run && (r_rd_left != '0) &&
                      !fifo_rgb_full && !r_skid_v;
  assign w_sob_rd   = w_run && !fifo_sobel_empty &&
                      (r_wr_left != '0);
  assign w_last     = w_run && (r_wr_left == '0);
  assign w_wd_fire  = w_run && !w_sob_rd && (r_wd == W_LIM);

  assign busy             = w_run;
  assign done             = (r_state == S_DONE);
  assign error            = (r_state == S_ERR);
  assign frame_count      = r_frame_count;
  assign in_mem_rd_en     = w_rd_issue;
  assign in_mem_addr      = r_rd_addr;
  assign fifo_rgb_wr_en   = w_run && (r_skid_v || r_pend) &&
                            !fifo_rgb_full;
  assign fifo_rgb_din     = r_skid_v ? r_skid :
                            (r_pend ? in_mem_rdata : '0);
  assign fifo_sobel_rd_en = w_sob_rd;
  assign out_mem_wr_en    = r_out_wr_en;
  assign out_mem_addr     = r_out_addr;
  assign out_mem_wdata    = r_out_wdata;

  // Frame state machine; completion wins over a coincident watchdog hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) r_state <= S_RUN;
        S_RUN: begin
          if (w_last)         r_state <= S_DONE;
          else if (w_wd_fire) r_state <= S_ERR;
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR:  r_state <= S_ERR;
      endcase
    end
  end

  // Address and remaining-pixel counters for both sides
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_left <= '0;
      r_wr_left <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else if (w_go) begin
      r_rd_left <= C_N;
      r_wr_left <= C_N;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else begin
      if (w_rd_issue) begin
        r_rd_addr <= r_rd_addr + A_ONE;
        r_rd_left <= r_rd_left - C_ONE;
      end
      if (w_sob_rd) begin
        r_wr_addr <= r_wr_addr + A_ONE;
        r_wr_left <= r_wr_left - C_ONE;
      end
    end
  end

  // Watchdog: idle RUN cycles since the last Sobel FIFO read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wd <= '0;
    end else if (w_go) begin
      r_wd <= '0;
    end else if (w_run) begin
      r_wd <= w_sob_rd ? '0 : r_wd + W_ONE;
    end
  end

  // Feed side: read-pending flag and one-word skid for a full FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend   <= 1'b0;
      r_skid_v <= 1'b0;
      r_skid   <= '0;
    end else if (!w_run) begin
      r_pend   <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_pend <= w_rd_issue;
      if (r_skid_v) begin
        if (!fifo_rgb_full) r_skid_v <= 1'b0;
      end else if (r_pend && fifo_rgb_full) begin
        r_skid   <= in_mem_rdata;
        r_skid_v <= 1'b1;
      end
    end
  end

  // Drain side: register the output memory write one cycle after the read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_wr_en <= 1'b0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
    end else begin
      r_out_wr_en <= w_sob_rd;
      if (w_sob_rd) begin
        r_out_addr  <= r_wr_addr;
        r_out_wdata <= fifo_sobel_dout;
      end
    end
  end

  // Completed-frame counter, wraps at 16 bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_count <= '0;
    end else if (w_last) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on an 8x4 frame with a
// 64-cycle watchdog; memories and FIFOs are modelled in the bench.
module tb_sobel_frame_ctrl;

  localparam int AW = 6;
  localparam int RW = 24;
  localparam int SW = 8;
  localparam int NP = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   frame_count;
  logic          in_mem_rd_en;
  logic [AW-1:0] in_mem_addr;
  logic [RW-1:0] in_mem_rdata;
  logic          fifo_rgb_wr_en;
  logic [RW-1:0] fifo_rgb_din;
  logic          fifo_rgb_full = 1'b0;
  logic          fifo_sobel_rd_en;
  logic [SW-1:0] fifo_sobel_dout;
  logic          fifo_sobel_empty;
  logic          out_mem_wr_en;
  logic [AW-1:0] out_mem_addr;
  logic [SW-1:0] out_mem_wdata;

  int checks = 0;
  int passed = 0;

  logic          sob_block = 1'b1;
  logic [7:0]    sob_cnt = 8'd0;
  logic          m_rd = 1'b0;
  logic          m_srd = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            cyc = 0;
  int            rd_cyc[$];
  logic [AW-1:0] rd_q[$];
  logic [RW-1:0] rgb_q[$];
  logic [AW-1:0] wa_q[$];
  logic [SW-1:0] wd_q[$];
  int            done_n = 0;
  int            done_cyc = 0;
  int            last_wr_cyc = 0;
  logic          busy_at_done = 1'b0;

  sobel_frame_ctrl #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .RGB_DWIDTH(RW),
    .SOBEL_DWIDTH(SW), .ADDR_WIDTH(AW), .TIMEOUT(64)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .frame_count(frame_count),
    .in_mem_rd_en(in_mem_rd_en), .in_mem_addr(in_mem_addr),
    .in_mem_rdata(in_mem_rdata),
    .fifo_rgb_wr_en(fifo_rgb_wr_en), .fifo_rgb_din(fifo_rgb_din),
    .fifo_rgb_full(fifo_rgb_full),
    .fifo_sobel_rd_en(fifo_sobel_rd_en),
    .fifo_sobel_dout(fifo_sobel_dout),
    .fifo_sobel_empty(fifo_sobel_empty),
    .out_mem_wr_en(out_mem_wr_en), .out_mem_addr(out_mem_addr),
    .out_mem_wdata(out_mem_wdata)
  );

  always #5 clock = ~clock;

  function automatic logic [RW-1:0] pix(input logic [AW-1:0] a);
    return {8'hAB, 10'd0, a};
  endfunction

  assign fifo_sobel_empty = sob_block;
  assign fifo_sobel_dout  = sob_cnt ^ 8'h5A;

  always @(negedge clock) begin
    cyc    <= cyc + 1;
    m_rd   <= in_mem_rd_en;
    m_addr <= in_mem_addr;
    m_srd  <= fifo_sobel_rd_en;
    if (in_mem_rd_en) begin
      rd_q.push_back(in_mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (fifo_rgb_wr_en) rgb_q.push_back(fifo_rgb_din);
    if (out_mem_wr_en) begin
      wa_q.push_back(out_mem_addr);
      wd_q.push_back(out_mem_wdata);
      last_wr_cyc <= cyc;
    end
    if (done) begin
      done_n       <= done_n + 1;
      done_cyc     <= cyc;
      busy_at_done <= busy;
    end
  end

  always @(posedge clock) begin
    if (m_rd) in_mem_rdata <= pix(m_addr);
    if (m_srd) sob_cnt <= sob_cnt + 8'd1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    rd_cyc.delete();
    rgb_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    sob_block = 1'b0;
    #12;
    checks++;
    if ({busy, done, error} !== 3'b000)
      $display("FAIL rst_status: got %b want 000", {busy, done, error});
    else passed++;
    checks++;
    if (frame_count !== 16'd0)
      $display("FAIL rst_fc: got %0d want 0", frame_count);
    else passed++;
    checks++;
    if ({in_mem_rd_en, fifo_rgb_wr_en, fifo_sobel_rd_en,
         out_mem_wr_en} !== 4'b0000)
      $display("FAIL rst_strobes: got %b want 0000",
               {in_mem_rd_en, fifo_rgb_wr_en, fifo_sobel_rd_en,
                out_mem_wr_en});
    else passed++;
    checks++;
    if ({in_mem_addr, fifo_rgb_din, out_mem_addr,
         out_mem_wdata} !== '0)
      $display("FAIL rst_data: got %h want 0",
               {in_mem_addr, fifo_rgb_din, out_mem_addr,
                out_mem_wdata});
    else passed++;
    sob_block = 1'b1;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_frame();
    bit ok;
    int bad;
    int d0;
    logic [7:0] base;
    clear_logs();
    sob_block = 1'b0;
    base = sob_cnt;
    d0 = done_n;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || in_mem_rd_en !== 1'b1 || in_mem_addr !== '0)
      $display("FAIL frame_first: busy %b rd %b addr %0d want 1 1 0",
               busy, in_mem_rd_en, in_mem_addr);
    else passed++;
    wait_done(ok);
    checks++;
    if (ok !== 1'b1)
      $display("FAIL frame_timeout: done %b want 1", ok);
    else passed++;
    repeat (3) step();
    bad = 0;
    for (int i = 0; i < NP; i++)
      if (i >= rd_q.size() || rd_q[i] !== AW'(i) ||
          i >= rgb_q.size() || rgb_q[i] !== pix(AW'(i))) bad++;
    checks++;
    if (bad != 0 || rd_q.size() != NP || rgb_q.size() != NP)
      $display("FAIL frame_feed: rd %0d rgb %0d bad %0d want 32 32 0",
               rd_q.size(), rgb_q.size(), bad);
    else passed++;
    checks++;
    if (rd_cyc.size() != NP || rd_cyc[NP-1] - rd_cyc[0] != NP - 1)
      $display("FAIL frame_rate: span %0d want 31",
               rd_cyc[rd_cyc.size()-1] - rd_cyc[0]);
    else passed++;
    bad = 0;
    for (int i = 0; i < NP; i++)
      if (i >= wa_q.size() || wa_q[i] !== AW'(i) ||
          wd_q[i] !== ((base + 8'(i)) ^ 8'h5A)) bad++;
    checks++;
    if (bad != 0 || wa_q.size() != NP)
      $display("FAIL frame_drain: wr %0d bad %0d want 32 0",
               wa_q.size(), bad);
    else passed++;
    checks++;
    if (done_n - d0 != 1)
      $display("FAIL frame_done_n: got %0d want 1", done_n - d0);
    else passed++;
    checks++;
    if (done_cyc != last_wr_cyc + 1 || busy_at_done !== 1'b0)
      $display("FAIL frame_done_t: dc %0d lw %0d busy %b want +1 0",
               done_cyc, last_wr_cyc, busy_at_done);
    else passed++;
    checks++;
    if (frame_count !== 16'd1)
      $display("FAIL frame_fc: got %0d want 1", frame_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    clear_logs();
    sob_block = 1'b1;
    pulse_start();
    step();
    step();
    step();
    fifo_rgb_full = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      if (in_mem_rd_en !== 1'b0 || fifo_rgb_wr_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL bp_stall: bad cycles %0d want 0", bad);
    else passed++;
    step();
    fifo_rgb_full = 1'b0;
    #1;
    checks++;
    if (fifo_rgb_wr_en !== 1'b1 || fifo_rgb_din !== pix(6'd2) ||
        in_mem_rd_en !== 1'b0)
      $display("FAIL bp_skid: wr %b din %h rd %b want 1 %h 0",
               fifo_rgb_wr_en, fifo_rgb_din, in_mem_rd_en,
               pix(6'd2));
    else passed++;
    step();
    sob_block = 1'b0;
    checks++;
    if (in_mem_rd_en !== 1'b1 || in_mem_addr !== 6'd3)
      $display("FAIL bp_resume: rd %b addr %0d want 1 3",
               in_mem_rd_en, in_mem_addr);
    else passed++;
    wait_done(ok);
    checks++;
    if (ok !== 1'b1)
      $display("FAIL bp_timeout: done %b want 1", ok);
    else passed++;
    repeat (2) step();
    bad = 0;
    for (int i = 0; i < NP; i++)
      if (i >= rgb_q.size() || rgb_q[i] !== pix(AW'(i)) ||
          i >= rd_q.size() || rd_q[i] !== AW'(i)) bad++;
    checks++;
    if (bad != 0 || rgb_q.size() != NP || rd_q.size() != NP)
      $display("FAIL bp_order: rgb %0d rd %0d bad %0d want 32 32 0",
               rgb_q.size(), rd_q.size(), bad);
    else passed++;
    checks++;
    if (frame_count !== 16'd2)
      $display("FAIL bp_fc: got %0d want 2", frame_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0;
    clear_logs();
    sob_block = 1'b0;
    d0 = done_n;
    pulse_start();
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(ok);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (ok !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_ign_done: done %b busy %b want 1 0", ok, busy);
    else passed++;
    checks++;
    if (rd_q.size() != NP || frame_count !== 16'd3)
      $display("FAIL b2b_ign_run: rd %0d fc %0d want 32 3",
               rd_q.size(), frame_count);
    else passed++;
    pulse_start();
    wait_done(ok);
    step();
    checks++;
    if (ok !== 1'b1 || done_n - d0 != 2)
      $display("FAIL b2b_done_n: got %0d want 2", done_n - d0);
    else passed++;
    checks++;
    if (frame_count !== 16'd4)
      $display("FAIL b2b_fc: got %0d want 4", frame_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    clear_logs();
    sob_block = 1'b0;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (in_mem_rd_en && in_mem_addr == 6'd13) break;
      step();
    end
    checks++;
    if (in_mem_addr !== 6'd13)
      $display("FAIL rmid_reach: addr %0d want 13", in_mem_addr);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, frame_count, in_mem_rd_en, in_mem_addr,
         fifo_rgb_wr_en, fifo_rgb_din, fifo_sobel_rd_en,
         out_mem_wr_en, out_mem_addr, out_mem_wdata} !== '0)
      $display("FAIL rmid_zero: got %h want 0",
               {busy, done, error, frame_count, in_mem_rd_en,
                in_mem_addr, fifo_rgb_wr_en, fifo_rgb_din,
                fifo_sobel_rd_en, out_mem_wr_en, out_mem_addr,
                out_mem_wdata});
    else passed++;
    step();
    reset = 1'b1;
    step();
    clear_logs();
    pulse_start();
    wait_done(ok);
    repeat (2) step();
    bad = 0;
    for (int i = 0; i < NP; i++)
      if (i >= rgb_q.size() || rgb_q[i] !== pix(AW'(i)) ||
          i >= rd_q.size() || rd_q[i] !== AW'(i)) bad++;
    checks++;
    if (ok !== 1'b1 || bad != 0 || rgb_q.size() != NP)
      $display("FAIL rmid_restart: rgb %0d bad %0d want 32 0",
               rgb_q.size(), bad);
    else passed++;
    checks++;
    if (frame_count !== 16'd1)
      $display("FAIL rmid_fc: got %0d want 1", frame_count);
    else passed++;
  endtask

  task automatic test_timeout();
    int n;
    sob_block = 1'b1;
    pulse_start();
    n = busy ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      if (error) break;
      step();
      if (busy) n++;
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0)
      $display("FAIL wd_fire: error %b busy %b want 1 0", error, busy);
    else passed++;
    checks++;
    if (n != 64)
      $display("FAIL wd_cycles: got %0d want 64", n);
    else passed++;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL wd_sticky: err %b busy %b done %b want 1 0 0",
               error, busy, done);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (error !== 1'b0 || frame_count !== 16'd0)
      $display("FAIL wd_clear: err %b fc %0d want 0 0",
               error, frame_count);
    else passed++;
    step();
    reset = 1'b1;
    sob_block = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    bit ok;
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    #1;
    checks++;
    if (frame_count !== 16'hFFFF)
      $display("FAIL wrap_pre: got %h want ffff", frame_count);
    else passed++;
    step();
    pulse_start();
    wait_done(ok);
    step();
    checks++;
    if (ok !== 1'b1 || frame_count !== 16'd0)
      $display("FAIL wrap_fc: done %b fc %h want 1 0000",
               ok, frame_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
